// File: rtl/mac_tx_arbiter_if.sv
// Connection bundle for mac_tx_arbiter: two byte-stream requesters plus the shared mac_transmit port.
// The slave modport is the arbiter's view; master is the requesters and transmitter around it.
interface mac_tx_arbiter_if;
  logic [1:0]       req_valid;
  logic [1:0][7:0]  req_data;
  logic [1:0]       req_last;
  logic [1:0][47:0] req_mac_dest;
  logic [1:0]       req_ready;
  logic [1:0]       req_done;
  logic [7:0]       tx_data;
  logic             tx_data_valid;
  logic             tx_send;
  logic [47:0]      tx_mac_dest;
  logic             tx_busy;
  logic             truncated;
  logic [1:0]       grant;

  modport master (
    output req_valid, req_data, req_last, req_mac_dest, tx_busy,
    input  req_ready, req_done, tx_data, tx_data_valid, tx_send, tx_mac_dest,
           truncated, grant
  );

  modport slave (
    input  req_valid, req_data, req_last, req_mac_dest, tx_busy,
    output req_ready, req_done, tx_data, tx_data_valid, tx_send, tx_mac_dest,
           truncated, grant
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Round-robin owner of a single mac_transmit: loads one packet at a time into its buffer,
// pads to MIN_PAYLOAD, drops bytes beyond MAX_PAYLOAD, then fires send_data and waits for the frame.
module mac_tx_arbiter #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic            clk_100mhz,
  input  logic            rst,
  mac_tx_arbiter_if.slave bus
);

  localparam logic [15:0] MIN_CNT = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_CNT = 16'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    SEND,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_data_valid_q, tx_data_valid_d;
  logic        tx_send_q, tx_send_d;
  logic [47:0] tx_mac_dest_q, tx_mac_dest_d;
  logic [1:0]  req_done_q, req_done_d;
  logic        truncated_q, truncated_d;

  logic [1:0]  req_ready;
  logic        sel;
  logic        g_idx;
  logic        accept;
  logic [15:0] count_inc;

  // On a tie the pointer decides; otherwise whichever single requester is valid wins.
  assign sel       = (bus.req_valid == 2'b11) ? rr_ptr_q : bus.req_valid[1];
  assign g_idx     = grant_q[1];
  assign req_ready = (state_q == LOAD && !bus.tx_busy) ? grant_q : 2'b00;
  assign accept    = |(req_ready & bus.req_valid);
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    count_d         = count_q;
    tx_data_d       = tx_data_q;
    tx_data_valid_d = 1'b0;
    tx_send_d       = 1'b0;
    tx_mac_dest_d   = tx_mac_dest_q;
    req_done_d      = 2'b00;
    truncated_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.tx_busy && (|bus.req_valid)) begin
          grant_d       = sel ? 2'b10 : 2'b01;
          tx_mac_dest_d = bus.req_mac_dest[sel];
          state_d       = LOAD;
        end
      end

      LOAD: begin
        if (accept) begin
          count_d = count_inc;
          if (count_q < MAX_CNT) begin
            tx_data_d       = bus.req_data[g_idx];
            tx_data_valid_d = 1'b1;
          end
          if (bus.req_last[g_idx]) begin
            truncated_d = (count_q >= MAX_CNT);
            state_d     = (count_inc < MIN_CNT) ? PAD : SEND;
          end
        end
      end

      PAD: begin
        if (!bus.tx_busy) begin
          tx_data_d       = 8'h00;
          tx_data_valid_d = 1'b1;
          count_d         = count_inc;
          if (count_inc >= MIN_CNT) begin
            state_d = SEND;
          end
        end
      end

      // tx_send is registered, so it lands one cycle after the final data beat.
      SEND: begin
        tx_send_d = 1'b1;
        state_d   = WAIT_START;
      end

      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          req_done_d = grant_q;
          rr_ptr_d   = ~g_idx;
          grant_d    = 2'b00;
          count_d    = 16'd0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q         <= IDLE;
      grant_q         <= 2'b00;
      rr_ptr_q        <= 1'b0;
      count_q         <= 16'd0;
      tx_data_q       <= 8'h00;
      tx_data_valid_q <= 1'b0;
      tx_send_q       <= 1'b0;
      tx_mac_dest_q   <= 48'd0;
      req_done_q      <= 2'b00;
      truncated_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      rr_ptr_q        <= rr_ptr_d;
      count_q         <= count_d;
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      tx_send_q       <= tx_send_d;
      tx_mac_dest_q   <= tx_mac_dest_d;
      req_done_q      <= req_done_d;
      truncated_q     <= truncated_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.req_done      = req_done_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign bus.tx_send       = tx_send_q;
  assign bus.tx_mac_dest   = tx_mac_dest_q;
  assign bus.truncated     = truncated_q;
  assign bus.grant         = grant_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: a packet table plus hand-written round-robin,
// mid-load reset and held-busy sequences, against a simple mac_transmit busy model.
module tb_mac_tx_arbiter;

  localparam int          MIN_P = 46;
  localparam int          MAX_P = 64;
  localparam logic [47:0] MAC0  = 48'h02AA_0000_0A0A;
  localparam logic [47:0] MAC1  = 48'h02BB_0000_0B0B;

  typedef struct {
    int         req;
    int         len;
    int         gap_at;
    int         gap_len;
    int         busy_len;
    int         exp_beats;
    int         exp_trunc;
    logic [1:0] exp_grant;
  } vec_t;

  logic clk_100mhz = 1'b0;
  logic rst        = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  mac_tx_arbiter_if bif();

  mac_tx_arbiter #(.MIN_PAYLOAD(MIN_P), .MAX_PAYLOAD(MAX_P)) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .bus       (bif)
  );

  logic       drv_valid [2];
  logic [7:0] drv_data  [2];
  logic       drv_last  [2];
  logic       model_busy;
  logic       force_busy;

  assign bif.req_valid    = {drv_valid[1], drv_valid[0]};
  assign bif.req_data     = {drv_data[1], drv_data[0]};
  assign bif.req_last     = {drv_last[1], drv_last[0]};
  assign bif.req_mac_dest = {MAC1, MAC0};
  assign bif.tx_busy      = model_busy | force_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  int         cyc = 0;
  int         beats, sends, truncs, both_ready_err, busy_valid_err, mac_err;
  int         beats_at_send, fall_cyc, done_cyc;
  int         dones [2];
  int         busy_len_cfg;
  logic [7:0] bytes_q [$];
  logic [1:0] grant_log [$];
  logic [1:0] prev_grant = 2'b00;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Monitor: tx_send is examined before the beat counter moves, so a send coincident
  // with the final beat shows up as one beat short.
  always @(negedge clk_100mhz) begin
    if (!rst) begin
      if (bif.tx_send) begin
        sends++;
        beats_at_send = beats;
      end
      if (bif.tx_data_valid) begin
        beats++;
        bytes_q.push_back(bif.tx_data);
      end
      if (bif.truncated) truncs++;
      if (bif.req_done[0]) begin dones[0]++; done_cyc = cyc; end
      if (bif.req_done[1]) begin dones[1]++; done_cyc = cyc; end
      if (bif.req_ready == 2'b11) both_ready_err++;
      if (bif.tx_data_valid && bif.tx_busy) busy_valid_err++;
      if (bif.grant == 2'b01 && bif.tx_mac_dest != MAC0) mac_err++;
      if (bif.grant == 2'b10 && bif.tx_mac_dest != MAC1) mac_err++;
      if (bif.grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(bif.grant);
    end
    prev_grant = bif.grant;
  end

  // mac_transmit stand-in: busy rises two cycles after send_data and stays up busy_len_cfg cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (!rst && bif.tx_send) begin
        repeat (2) @(negedge clk_100mhz);
        model_busy = 1'b1;
        repeat (busy_len_cfg) @(negedge clk_100mhz);
        model_busy = 1'b0;
        fall_cyc   = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name, input int waited);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: gave up after %0d cycles, required completion", name, waited);
  endtask

  task automatic send_pkt(input int r, input int len, input int gap_at, input int gap_len,
                          input int stop_at);
    int i     = 0;
    int gl    = gap_len;
    int guard = 0;
    while (i < len && i < stop_at) begin
      @(negedge clk_100mhz);
      guard++;
      if (guard > 5000) begin
        report_timeout($sformatf("send_pkt_req%0d", r), guard);
        break;
      end
      if (i == gap_at && gl > 0) begin
        drv_valid[r] = 1'b0;
        gl--;
      end else begin
        drv_valid[r] = 1'b1;
        drv_data[r]  = 8'(i + 1);
        drv_last[r]  = (i == len - 1);
        #1;
        if (bif.req_ready[r]) i++;
      end
    end
    @(negedge clk_100mhz);
    drv_valid[r] = 1'b0;
    drv_last[r]  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard = 0;
    while ((dones[0] + dones[1]) < target && guard < 4000) begin
      @(negedge clk_100mhz);
      guard++;
    end
    if ((dones[0] + dones[1]) < target) report_timeout("wait_done", guard);
  endtask

  task automatic apply_stimulus(input int tag, input vec_t v);
    int         b_beats, b_sends, b_trunc, b_d0, b_d1, b_mac, b_bq, b_gl, err;
    logic [7:0] exp_byte;
    logic [1:0] got_grant;
    b_beats = beats;   b_sends = sends;   b_trunc = truncs;
    b_d0    = dones[0]; b_d1   = dones[1]; b_mac  = mac_err;
    b_bq    = bytes_q.size(); b_gl = grant_log.size();
    busy_len_cfg = v.busy_len;

    send_pkt(v.req, v.len, v.gap_at, v.gap_len, v.len);
    wait_done(b_d0 + b_d1 + 1);
    repeat (3) @(negedge clk_100mhz);

    check_output($sformatf("v%0d_beats", tag), beats - b_beats, v.exp_beats);
    check_output($sformatf("v%0d_beats_before_send", tag), beats_at_send - b_beats, v.exp_beats);
    check_output($sformatf("v%0d_send_pulses", tag), sends - b_sends, 1);
    check_output($sformatf("v%0d_truncated", tag), truncs - b_trunc, v.exp_trunc);
    check_output($sformatf("v%0d_done0", tag), dones[0] - b_d0, (v.req == 0) ? 1 : 0);
    check_output($sformatf("v%0d_done1", tag), dones[1] - b_d1, (v.req == 1) ? 1 : 0);
    check_output($sformatf("v%0d_done_delay", tag), done_cyc - fall_cyc, 1);
    check_output($sformatf("v%0d_mac_dest_errs", tag), mac_err - b_mac, 0);
    got_grant = (grant_log.size() > b_gl) ? grant_log[b_gl] : 2'b00;
    check_output($sformatf("v%0d_grant", tag), got_grant, v.exp_grant);

    err = 0;
    for (int k = 0; k < v.exp_beats; k++) begin
      exp_byte = (k < v.len && k < MAX_P) ? 8'(k + 1) : 8'h00;
      if (b_bq + k >= bytes_q.size()) err++;
      else if (bytes_q[b_bq + k] !== exp_byte) err++;
    end
    check_output($sformatf("v%0d_payload_errs", tag), err, 0);
  endtask

  vec_t       vecs [8];
  int         b_beats, b_sends, b_d0, b_d1, b_gl, b_bq, err, early;
  logic [7:0] exp_byte;
  vec_t       v_after_rst;

  initial begin
    vecs[0] = '{0, 10, -1, 0, 20, 46, 0, 2'b01};
    vecs[1] = '{1, 60, 30, 5,  8, 60, 0, 2'b10};
    vecs[2] = '{0, 70, -1, 0,  8, 64, 1, 2'b01};
    vecs[3] = '{1,  1, -1, 0,  4, 46, 0, 2'b10};
    vecs[4] = '{0, 46, -1, 0,  4, 46, 0, 2'b01};
    vecs[5] = '{1, 64, -1, 0,  4, 64, 0, 2'b10};
    vecs[6] = '{0, 65, -1, 0,  4, 64, 1, 2'b01};
    vecs[7] = '{1, 45, -1, 0,  4, 46, 0, 2'b10};
    v_after_rst = '{1, 12, -1, 0, 6, 46, 0, 2'b10};

    for (int r = 0; r < 2; r++) begin
      drv_valid[r] = 1'b0;
      drv_data[r]  = 8'h00;
      drv_last[r]  = 1'b0;
    end
    force_busy   = 1'b0;
    busy_len_cfg = 6;

    repeat (4) @(negedge clk_100mhz);
    check_output("rst_grant", bif.grant, 2'b00);
    check_output("rst_req_ready", bif.req_ready, 2'b00);
    check_output("rst_req_done", bif.req_done, 2'b00);
    check_output("rst_tx_data_valid", bif.tx_data_valid, 1'b0);
    check_output("rst_tx_send", bif.tx_send, 1'b0);
    check_output("rst_tx_data", bif.tx_data, 8'h00);
    check_output("rst_tx_mac_dest", bif.tx_mac_dest, 48'd0);
    check_output("rst_truncated", bif.truncated, 1'b0);

    // Both requesters pending from reset release: expect req0, req1, req0.
    drv_valid[0] = 1'b1;
    drv_valid[1] = 1'b1;
    rst = 1'b0;
    fork
      begin
        send_pkt(0, 50, -1, 0, 50);
        send_pkt(0, 50, -1, 0, 50);
      end
      send_pkt(1, 50, -1, 0, 50);
    join
    wait_done(3);
    repeat (3) @(negedge clk_100mhz);
    check_output("rr_grant_count", grant_log.size(), 3);
    check_output("rr_grant_first", (grant_log.size() > 0) ? grant_log[0] : 2'b00, 2'b01);
    check_output("rr_grant_second", (grant_log.size() > 1) ? grant_log[1] : 2'b00, 2'b10);
    check_output("rr_grant_third", (grant_log.size() > 2) ? grant_log[2] : 2'b00, 2'b01);
    check_output("rr_beats", beats, 150);
    check_output("rr_sends", sends, 3);
    check_output("rr_done0", dones[0], 2);
    check_output("rr_done1", dones[1], 1);
    check_output("rr_both_ready", both_ready_err, 0);
    err = 0;
    for (int k = 0; k < 150; k++) begin
      exp_byte = 8'((k % 50) + 1);
      if (k >= bytes_q.size()) err++;
      else if (bytes_q[k] !== exp_byte) err++;
    end
    check_output("rr_payload_errs", err, 0);

    for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);

    // Reset after 20 bytes of a req0 packet, then a req1 packet must go through cleanly.
    b_sends = sends;
    send_pkt(0, 40, -1, 0, 20);
    rst = 1'b1;
    @(negedge clk_100mhz);
    check_output("midrst_grant", bif.grant, 2'b00);
    check_output("midrst_req_ready", bif.req_ready, 2'b00);
    check_output("midrst_tx_data_valid", bif.tx_data_valid, 1'b0);
    check_output("midrst_tx_send", bif.tx_send, 1'b0);
    check_output("midrst_tx_mac_dest", bif.tx_mac_dest, 48'd0);
    rst = 1'b0;
    check_output("midrst_no_send", sends - b_sends, 0);
    apply_stimulus(8, v_after_rst);

    // tx_busy held externally: no grant until the cycle after it drops.
    busy_len_cfg = 5;
    force_busy   = 1'b1;
    b_d0 = dones[0]; b_d1 = dones[1]; b_beats = beats; b_gl = grant_log.size();
    b_bq = bytes_q.size();
    early = 0;
    fork
      send_pkt(0, 8, -1, 0, 8);
      begin
        repeat (10) begin
          @(negedge clk_100mhz);
          #2;
          if (bif.grant != 2'b00) early++;
        end
        check_output("busyhold_no_grant", early, 0);
        force_busy = 1'b0;
        @(negedge clk_100mhz);
        #2;
        check_output("busyhold_grant_next_cycle", bif.grant, 2'b01);
      end
    join
    wait_done(b_d0 + b_d1 + 1);
    repeat (3) @(negedge clk_100mhz);
    check_output("busyhold_done0", dones[0] - b_d0, 1);
    check_output("busyhold_beats", beats - b_beats, 46);
    check_output("busyhold_grant_log", grant_log.size() - b_gl, 1);
    check_output("busyhold_first_byte", (bytes_q.size() > b_bq) ? bytes_q[b_bq] : 8'hFF, 8'h01);

    check_output("valid_while_busy", busy_valid_err, 0);
    check_output("both_ready_total", both_ready_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
